mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single on-board memory port (21-bit word address, 32-bit data) between two requesters:
  - the PCI host path;
  - the FPGA user/compute sequencer.
- Routes read returns back to the requester that issued them.
- Lets the user sequencer take exclusive ownership of memory during a compute set. Host accesses to the flag word always pass.
- Sits between the PCI bridge / user sequencer and the memory controller.

Parameters:
- AW, 21, address width.
- DW, 32, data width.
- FLAG_ADDR, 21'h07FFFE, host/FPGA handshake flag word; host access here is never blocked.
- MAX_OUT, 4, maximum outstanding reads (1..8).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- h_req  in  1  host request; held until h_gnt
- h_we  in  1  host write(1)/read(0)
- h_addr  in  AW  host address
- h_wdata  in  DW  host write data
- h_gnt  out  1  host request accepted this cycle
- h_rvalid  out  1  host read data valid
- h_rdata  out  DW  host read data
- u_req  in  1  user request; held until u_gnt
- u_we  in  1  user write(1)/read(0)
- u_addr  in  AW  user address
- u_wdata  in  DW  user write data
- u_gnt  out  1  user request accepted
- u_rvalid  out  1  user read data valid
- u_rdata  out  DW  user read data
- u_lock  in  1  user requests exclusive ownership
- lock_ack  out  1  exclusive ownership in force
- mem_req  out  1  memory command valid
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rvalid  in  1  memory read data valid (in order)
- mem_rdata  in  DW  memory read data
- rtn_err  out  1  sticky: mem_rvalid with no outstanding read

Behaviour:
- Reset values: all outputs 0. FSM=OPEN. Round-robin pointer favours user. Tag FIFO empty. Outstanding count 0.
- Grant (h_gnt/u_gnt):
  - combinational, at most one per cycle, one-cycle pulse per accepted transaction;
  - a requester deasserts req or presents the next transaction the cycle after its gnt.
- Issue: mem_req/mem_we/mem_addr/mem_wdata are registered copies of the granted transaction, so the command appears exactly 1 cycle after gnt. mem_req=0 when no grant.
- Eligibility:
  - host flag access (h_addr==FLAG_ADDR) is always eligible;
  - host non-flag access is eligible only in OPEN;
  - user access is always eligible;
  - a read of either requester is ineligible while outstanding==MAX_OUT; writes are unaffected.
- Priority:
  - eligible host flag access wins outright;
  - otherwise round-robin between eligible requesters; the pointer flips to the other requester after each grant.
- Tag FIFO (depth MAX_OUT, 1-bit ID, 0=host, 1=user):
  - push on read grant;
  - pop on mem_rvalid; route mem_rdata combinationally to h_rdata/u_rdata with the matching rvalid in the same cycle;
  - the non-selected rdata holds its last value;
  - simultaneous push and pop leaves outstanding unchanged.
- mem_rvalid with FIFO empty: no rvalid, rtn_err<=1 (sticky until reset), count stays 0.
- FSM:
  - OPEN: u_lock=1 -> DRAIN.
  - DRAIN: host non-flag blocked; when no host read is outstanding -> LOCKED (same cycle as the last host return if it drains then); u_lock=0 -> OPEN.
  - LOCKED: lock_ack=1 (registered, asserted the cycle after entry); u_lock=0 -> OPEN, lock_ack=0 the cycle after.
- Host request pending in DRAIN/LOCKED: held, not dropped; granted on return to OPEN.
- Reset mid-operation: FIFO/count cleared, in-flight returns discarded, FSM=OPEN.

Decomposition:
- Shared package mem_arb_pkg:
  - requester ID enum (REQ_HOST, REQ_USER);
  - FSM enum (OPEN, DRAIN, LOCKED);
  - FLAG_ADDR default.
- One sub-module, tag_fifo: parameterized depth, 1-bit payload, push/pop/count/empty/full.

Test Plan:
- Host write 0x0000_0010 data 0xA5A5A5A5 alone -> h_gnt same cycle; next cycle mem_req=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5A5A5A5.
- Both requesters reading continuously, mem return latency 2 -> grants alternate U,H,U,H; each rdata reaches the issuing requester in order; no cross-routing.
- u_lock=1 while 2 host reads are outstanding:
  - DRAIN held until the 2nd return;
  - lock_ack rises the cycle after;
  - host read of 0x100 stalls until u_lock=0, then is granted.
- In LOCKED, host write to 0x07FFFE -> granted immediately, even if user req is pending.
- 4 user reads with memory stalled -> 5th user read not granted, outstanding=4; a user write in between is granted; the 5th read is granted the cycle after the first return.
- mem_rvalid with nothing outstanding -> no rvalid, rtn_err=1; rst_n pulse clears it and all state.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and defaults for the memory port arbiter
// Revision    : 1.0
// ============================================================================
package mem_arb_pkg;

   localparam logic [20:0] FLAG_ADDR_DEFAULT = 21'h07FFFE;

   typedef enum logic {
      REQ_HOST = 1'b0,
      REQ_USER = 1'b1
   } req_id_e;

   typedef enum logic [1:0] {
      OPEN   = 2'd0,
      DRAIN  = 2'd1,
      LOCKED = 2'd2
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : host, user and memory-side signals of the arbiter
// Revision            : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
   parameter int AW = 21,
   parameter int DW = 32
);
   logic          h_req;
   logic          h_we;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_wdata;
   logic          h_gnt;
   logic          h_rvalid;
   logic [DW-1:0] h_rdata;

   logic          u_req;
   logic          u_we;
   logic [AW-1:0] u_addr;
   logic [DW-1:0] u_wdata;
   logic          u_gnt;
   logic          u_rvalid;
   logic [DW-1:0] u_rdata;
   logic          u_lock;
   logic          lock_ack;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rvalid;
   logic [DW-1:0] mem_rdata;
   logic          rtn_err;

   modport slave (
      input  h_req, h_we, h_addr, h_wdata,
      output h_gnt, h_rvalid, h_rdata,
      input  u_req, u_we, u_addr, u_wdata, u_lock,
      output u_gnt, u_rvalid, u_rdata, lock_ack,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rvalid, mem_rdata,
      output rtn_err
   );

   modport master (
      output h_req, h_we, h_addr, h_wdata,
      input  h_gnt, h_rvalid, h_rdata,
      output u_req, u_we, u_addr, u_wdata, u_lock,
      input  u_gnt, u_rvalid, u_rdata, lock_ack,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rvalid, mem_rdata,
      input  rtn_err
   );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// tag_fifo : in-order requester-ID queue for outstanding memory reads
// Revision : 1.0
// ============================================================================
module tag_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          push_id,
   input  logic          pop,
   output logic          pop_id,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] r_tags;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tags   <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_tags[r_wr_ptr] <= push_id;
            r_wr_ptr         <= ptr_inc(r_wr_ptr);
         end
         if (pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CW'(push) - CW'(pop);
      end
   end

   assign pop_id = r_tags[r_rd_ptr];
   assign count  = r_count;
   assign empty  = (r_count == '0);
   assign full   = (r_count == CW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between host and user sequencer
// Revision         : 1.0
// ============================================================================
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int            AW        = 21,
   parameter int            DW        = 32,
   parameter logic [AW-1:0] FLAG_ADDR = AW'(FLAG_ADDR_DEFAULT),
   parameter int            MAX_OUT   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.slave bus
);
   localparam int CW = $clog2(MAX_OUT + 1);

   arb_state_e    r_state;
   arb_state_e    w_state_nxt;
   req_id_e       r_rr_ptr;
   logic          r_lock_ack;
   logic          r_rtn_err;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic [DW-1:0] r_h_rdata;
   logic [DW-1:0] r_u_rdata;
   logic [CW-1:0] r_user_rd;

   logic          w_h_flag;
   logic          w_h_elig;
   logic          w_u_elig;
   logic          w_h_gnt;
   logic          w_u_gnt;
   logic          w_h_rd_gnt;
   logic          w_u_rd_gnt;
   logic          w_push;
   logic          w_pop;
   logic          w_pop_id;
   logic          w_h_ret;
   logic          w_u_ret;
   logic          w_fifo_empty;
   logic          w_fifo_full;
   logic [CW-1:0] w_fifo_count;
   logic [CW-1:0] w_host_rd_nxt;

   // Reads stall at the outstanding limit; writes never need a return slot.
   assign w_h_flag = (bus.h_addr == FLAG_ADDR);
   assign w_h_elig = bus.h_req && (w_h_flag || (r_state == OPEN)) && (bus.h_we || !w_fifo_full);
   assign w_u_elig = bus.u_req && (bus.u_we || !w_fifo_full);

   always_comb begin
      w_h_gnt = 1'b0;
      w_u_gnt = 1'b0;
      if (w_h_elig && w_h_flag) begin
         w_h_gnt = 1'b1;
      end else if (w_h_elig && w_u_elig) begin
         if (r_rr_ptr == REQ_USER) w_u_gnt = 1'b1;
         else                      w_h_gnt = 1'b1;
      end else if (w_h_elig) begin
         w_h_gnt = 1'b1;
      end else if (w_u_elig) begin
         w_u_gnt = 1'b1;
      end
   end

   assign w_h_rd_gnt = w_h_gnt & ~bus.h_we;
   assign w_u_rd_gnt = w_u_gnt & ~bus.u_we;
   assign w_push     = w_h_rd_gnt | w_u_rd_gnt;
   assign w_pop      = bus.mem_rvalid & ~w_fifo_empty;
   assign w_h_ret    = w_pop & (w_pop_id == REQ_HOST);
   assign w_u_ret    = w_pop & (w_pop_id == REQ_USER);

   tag_fifo #(
      .DEPTH (MAX_OUT),
      .CW    (CW)
   ) u_tag_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (w_push),
      .push_id (w_u_gnt),
      .pop     (w_pop),
      .pop_id  (w_pop_id),
      .count   (w_fifo_count),
      .empty   (w_fifo_empty),
      .full    (w_fifo_full)
   );

   // Host reads still in flight after this cycle's grant and return.
   assign w_host_rd_nxt = w_fifo_count - r_user_rd + CW'(w_h_rd_gnt) - CW'(w_h_ret);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         OPEN:    if (bus.u_lock) w_state_nxt = DRAIN;
         DRAIN: begin
            if (!bus.u_lock)               w_state_nxt = OPEN;
            else if (w_host_rd_nxt == '0)  w_state_nxt = LOCKED;
         end
         LOCKED:  if (!bus.u_lock) w_state_nxt = OPEN;
         default: w_state_nxt = OPEN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= OPEN;
         r_rr_ptr    <= REQ_USER;
         r_lock_ack  <= 1'b0;
         r_rtn_err   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_h_rdata   <= '0;
         r_u_rdata   <= '0;
         r_user_rd   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_ack <= (w_state_nxt == LOCKED);
         r_mem_req  <= w_h_gnt | w_u_gnt;
         r_user_rd  <= r_user_rd + CW'(w_u_rd_gnt) - CW'(w_u_ret);
         if (w_h_gnt) begin
            r_rr_ptr    <= REQ_USER;
            r_mem_we    <= bus.h_we;
            r_mem_addr  <= bus.h_addr;
            r_mem_wdata <= bus.h_wdata;
         end else if (w_u_gnt) begin
            r_rr_ptr    <= REQ_HOST;
            r_mem_we    <= bus.u_we;
            r_mem_addr  <= bus.u_addr;
            r_mem_wdata <= bus.u_wdata;
         end
         if (w_h_ret) r_h_rdata <= bus.mem_rdata;
         if (w_u_ret) r_u_rdata <= bus.mem_rdata;
         if (bus.mem_rvalid && w_fifo_empty) r_rtn_err <= 1'b1;
      end
   end

   assign bus.h_gnt     = w_h_gnt;
   assign bus.u_gnt     = w_u_gnt;
   assign bus.h_rvalid  = w_h_ret;
   assign bus.u_rvalid  = w_u_ret;
   assign bus.h_rdata   = w_h_ret ? bus.mem_rdata : r_h_rdata;
   assign bus.u_rdata   = w_u_ret ? bus.mem_rdata : r_u_rdata;
   assign bus.lock_ack  = r_lock_ack;
   assign bus.rtn_err   = r_rtn_err;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed + random bench with a queue-based reference
// Revision            : 1.0
// ============================================================================
module tb_mem_port_arbiter;
   localparam logic [20:0] FLAG = 21'h07FFFE;
   localparam int MAXO = 4;
   localparam int M_OPEN = 0, M_DRAIN = 1, M_LOCKED = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.AW(21), .DW(32)) bus ();

   mem_port_arbiter #(.AW(21), .DW(32), .FLAG_ADDR(FLAG), .MAX_OUT(MAXO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model: queue of return owners ----------------
   bit          m_q[$];
   int          m_mode;
   bit          m_ptr_user, m_err, e_req, e_we, e_lock;
   logic [20:0] e_addr;
   logic [31:0] e_wdata, e_hold_h, e_hold_u;

   function automatic void model_reset();
      m_q.delete();
      m_mode = M_OPEN; m_ptr_user = 1'b1; m_err = 1'b0;
      e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_lock = 1'b0;
      e_hold_h = '0; e_hold_u = '0;
   endfunction

   initial begin : model_check
      bit full, hflag, helig, uelig, gh, gu, pop, tag, xhv, xuv;
      logic [31:0] xhd, xud;
      int hcnt;
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) model_reset();
         full  = (m_q.size() >= MAXO);
         hflag = (bus.h_addr == FLAG);
         helig = bus.h_req && (hflag || m_mode == M_OPEN) && (bus.h_we || !full);
         uelig = bus.u_req && (bus.u_we || !full);
         gh = 1'b0; gu = 1'b0;
         if (helig && (hflag || !uelig || !m_ptr_user)) gh = 1'b1;
         else if (uelig) gu = 1'b1;
         pop = bus.mem_rvalid && (m_q.size() > 0);
         tag = pop ? m_q[0] : 1'b0;
         xhv = pop && !tag;
         xuv = pop && tag;
         xhd = xhv ? bus.mem_rdata : e_hold_h;
         xud = xuv ? bus.mem_rdata : e_hold_u;
         chk("h_gnt", bus.h_gnt, gh);
         chk("u_gnt", bus.u_gnt, gu);
         chk("h_rvalid", bus.h_rvalid, xhv);
         chk("u_rvalid", bus.u_rvalid, xuv);
         chk("h_rdata", bus.h_rdata, xhd);
         chk("u_rdata", bus.u_rdata, xud);
         chk("mem_req", bus.mem_req, e_req);
         if (e_req) begin
            chk("mem_we", bus.mem_we, e_we);
            chk("mem_addr", bus.mem_addr, e_addr);
            if (e_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
         end
         chk("lock_ack", bus.lock_ack, e_lock);
         chk("rtn_err", bus.rtn_err, m_err);
         if (rst_n) begin
            if (pop) begin
               void'(m_q.pop_front());
               if (tag) e_hold_u = bus.mem_rdata; else e_hold_h = bus.mem_rdata;
            end else if (bus.mem_rvalid) begin
               m_err = 1'b1;
            end
            e_req = gh || gu;
            if (gh) begin
               e_we = bus.h_we; e_addr = bus.h_addr; e_wdata = bus.h_wdata;
               m_ptr_user = 1'b1;
               if (!bus.h_we) m_q.push_back(1'b0);
            end
            if (gu) begin
               e_we = bus.u_we; e_addr = bus.u_addr; e_wdata = bus.u_wdata;
               m_ptr_user = 1'b0;
               if (!bus.u_we) m_q.push_back(1'b1);
            end
            hcnt = 0;
            foreach (m_q[i]) if (!m_q[i]) hcnt++;
            case (m_mode)
               M_OPEN:   if (bus.u_lock) m_mode = M_DRAIN;
               M_DRAIN:  if (!bus.u_lock) m_mode = M_OPEN; else if (hcnt == 0) m_mode = M_LOCKED;
               default:  if (!bus.u_lock) m_mode = M_OPEN;
            endcase
            e_lock = (m_mode == M_LOCKED);
         end
      end
   end

   // ---------------- stimulus: requesters and an in-order memory ------------
   bit hg_s, ug_s, mem_stall;
   int cyc = 0, mem_lat = 2, h_rv_cnt = 0, u_rv_cnt = 0;
   int rq[$];

   task automatic to_neg();
      @(negedge clk);
      hg_s = bus.h_gnt;
      ug_s = bus.u_gnt;
      if (bus.h_rvalid) h_rv_cnt++;
      if (bus.u_rvalid) u_rv_cnt++;
      if (rst_n && bus.mem_req && !bus.mem_we) rq.push_back(cyc + mem_lat);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
      cyc++;
      if (hg_s) bus.h_req = 1'b0;
      if (ug_s) bus.u_req = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      if (!mem_stall && rq.size() > 0 && rq[0] <= cyc) begin
         void'(rq.pop_front());
         bus.mem_rvalid = 1'b1;
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         to_neg();
         to_pos();
      end
   endtask

   task automatic do_reset();
      bus.h_req = 0; bus.u_req = 0; bus.u_lock = 0; bus.mem_rvalid = 0;
      mem_stall = 0; hg_s = 0; ug_s = 0;
      rst_n = 1'b0;
      rq.delete();
      step(2);
      rq.delete();
      rst_n = 1'b1;
   endtask

   task automatic host_txn(input bit we, input logic [20:0] a, input logic [31:0] d);
      bus.h_req = 1; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d;
   endtask

   task automatic user_txn(input bit we, input logic [20:0] a, input logic [31:0] d);
      bus.u_req = 1; bus.u_we = we; bus.u_addr = a; bus.u_wdata = d;
   endtask

   task automatic until_hgnt(input string nm);
      int k = 0;
      do begin to_neg(); to_pos(); k++; end while (!hg_s && k < 20);
      chk(nm, hg_s, 1);
   endtask

   task automatic until_ugnt(input string nm);
      int k = 0;
      do begin to_neg(); to_pos(); k++; end while (!ug_s && k < 20);
      chk(nm, ug_s, 1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] order;
      int ng, nret, k;
      bit got;
      bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
      bus.u_req = 0; bus.u_we = 0; bus.u_addr = '0; bus.u_wdata = '0;
      bus.u_lock = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
      #1;
      do_reset();

      // Reset values
      to_neg();
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_lock_ack", bus.lock_ack, 0);
      chk("rst_rtn_err", bus.rtn_err, 0);
      chk("rst_h_rdata", bus.h_rdata, 0);
      to_pos();

      // Single host write: grant now, command one cycle later
      host_txn(1, 21'h10, 32'hA5A5_A5A5);
      to_neg();
      chk("d1_h_gnt", bus.h_gnt, 1);
      chk("d1_u_gnt", bus.u_gnt, 0);
      to_pos();
      to_neg();
      chk("d1_mem_req", bus.mem_req, 1);
      chk("d1_mem_we", bus.mem_we, 1);
      chk("d1_mem_addr", bus.mem_addr, 21'h10);
      chk("d1_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
      to_pos();
      step(2);

      // Both reading back-to-back: U,H,U,H...
      do_reset();
      mem_lat = 2; order = '0; ng = 0; h_rv_cnt = 0; u_rv_cnt = 0;
      host_txn(0, 21'h200, 0);
      user_txn(0, 21'h300, 0);
      for (int i = 0; i < 12; i++) begin
         to_neg();
         if (hg_s || ug_s) begin
            if (ng < 8) order[7 - ng] = ug_s;
            ng++;
         end
         to_pos();
         if (hg_s) bus.h_addr = bus.h_addr + 21'd1;
         if (ug_s) bus.u_addr = bus.u_addr + 21'd1;
         bus.h_req = 1; bus.u_req = 1;
      end
      bus.h_req = 0; bus.u_req = 0;
      step(8);
      chk("d2_order", order, 8'b1010_1010);
      chk("d2_grants", ng, 12);
      chk("d2_host_returns", h_rv_cnt, 6);
      chk("d2_user_returns", u_rv_cnt, 6);

      // Lock while two host reads are outstanding
      do_reset();
      mem_stall = 1;
      host_txn(0, 21'h40, 0);
      until_hgnt("d3_gnt_a");
      host_txn(0, 21'h44, 0);
      until_hgnt("d3_gnt_b");
      bus.u_lock = 1;
      step(1);
      host_txn(0, 21'h100, 0);
      for (int i = 0; i < 3; i++) begin
         to_neg();
         chk("d3_drain_h_blocked", bus.h_gnt, 0);
         chk("d3_drain_no_ack", bus.lock_ack, 0);
         to_pos();
      end
      mem_stall = 0; nret = 0; got = 0; k = 0;
      while (k < 12 && !got) begin
         to_neg();
         k++;
         if (bus.h_rvalid) nret++;
         if (nret == 2) begin
            chk("d3_ack_at_last_ret", bus.lock_ack, 0);
            got = 1;
         end
         to_pos();
      end
      chk("d3_drained", got, 1);
      to_neg();
      chk("d3_ack_rise", bus.lock_ack, 1);
      chk("d3_locked_h_blocked", bus.h_gnt, 0);
      to_pos();
      step(3);
      bus.u_lock = 0;
      to_neg();
      chk("d3_unlock_same_cycle", bus.h_gnt, 0);
      to_pos();
      to_neg();
      chk("d3_unlock_grant", bus.h_gnt, 1);
      chk("d3_ack_fall", bus.lock_ack, 0);
      to_pos();

      // Flag write in LOCKED wins over a pending user read
      step(4);
      bus.u_lock = 1;
      got = 0; k = 0;
      while (k < 12 && !got) begin
         to_neg(); k++;
         if (bus.lock_ack) got = 1;
         to_pos();
      end
      chk("d4_locked", got, 1);
      user_txn(0, 21'h500, 0);
      host_txn(1, FLAG, 32'h1234_5678);
      to_neg();
      chk("d4_flag_h_gnt", bus.h_gnt, 1);
      chk("d4_flag_u_gnt", bus.u_gnt, 0);
      to_pos();
      to_neg();
      chk("d4_user_next", bus.u_gnt, 1);
      chk("d4_flag_mem_addr", bus.mem_addr, FLAG);
      to_pos();
      bus.u_lock = 0;
      step(6);

      // Outstanding limit: writes pass, 5th read waits for a return
      do_reset();
      mem_stall = 1;
      for (int i = 0; i < 4; i++) begin
         user_txn(0, 21'h600 + 21'(i), 0);
         until_ugnt("d5_read_gnt");
      end
      user_txn(0, 21'h700, 0);
      for (int i = 0; i < 2; i++) begin
         to_neg();
         chk("d5_read_blocked", bus.u_gnt, 0);
         to_pos();
      end
      user_txn(1, 21'h710, 32'hCAFE_F00D);
      to_neg();
      chk("d5_write_passes", bus.u_gnt, 1);
      to_pos();
      user_txn(0, 21'h700, 0);
      to_neg();
      chk("d5_still_blocked", bus.u_gnt, 0);
      mem_stall = 0;
      to_pos();
      to_neg();
      chk("d5_first_return", bus.u_rvalid, 1);
      chk("d5_blocked_at_return", bus.u_gnt, 0);
      to_pos();
      to_neg();
      chk("d5_grant_after_return", bus.u_gnt, 1);
      to_pos();
      step(10);

      // Spurious return flags an error that only reset clears
      bus.mem_rvalid = 1;
      to_neg();
      chk("d6_no_h_rvalid", bus.h_rvalid, 0);
      chk("d6_no_u_rvalid", bus.u_rvalid, 0);
      to_pos();
      to_neg();
      chk("d6_rtn_err_set", bus.rtn_err, 1);
      to_pos();
      step(2);
      to_neg();
      chk("d6_rtn_err_sticky", bus.rtn_err, 1);
      to_pos();
      do_reset();
      to_neg();
      chk("d6_rtn_err_cleared", bus.rtn_err, 0);
      to_pos();

      // Random traffic, each segment ends with a mid-operation reset
      for (int seg = 0; seg < 4; seg++) begin
         mem_lat = seg + 1;
         for (int i = 0; i < 600; i++) begin
            to_neg();
            to_pos();
            if (!bus.h_req && $urandom_range(0, 3) != 0)
               host_txn(1'($urandom_range(0, 1)),
                        ($urandom_range(0, 5) == 0) ? FLAG : 21'($urandom_range(0, 255)),
                        $urandom);
            if (!bus.u_req && $urandom_range(0, 3) != 0)
               user_txn(1'($urandom_range(0, 1)), 21'($urandom_range(0, 255)), $urandom);
            if ($urandom_range(0, 29) == 0) bus.u_lock = ~bus.u_lock;
            mem_stall = ($urandom_range(0, 5) == 0);
         end
         do_reset();
         step(3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
